gato_board_ctrl: RTL and testbench
==================================

Name: gato_board_ctrl

Overview:
- Sequential stage directly downstream of the cursor-arithmetic stage in the tic-tac-toe (gato) design.
- Registers the cursor position proposed by that stage. The registered position is fed back to it as the current posX/posY.
- Owns the 3x3 board and places marks on "select". Alternates players.
- Detects win and draw through a small FSM and drives board state to the display stage.

Parameters:
- GRID, 3, board side length; fixed at 3, and position/line logic assumes it.
- POS_W, 3, width of position coordinates; matches the 3-bit arithmetic-stage outputs.

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  reset, synchronous, active-high
- move_valid  in  1  one-cycle pulse: next_x/next_y hold a new cursor proposal
- next_x  in  3  proposed column from the arithmetic stage
- next_y  in  3  proposed row from the arithmetic stage
- select  in  1  one-cycle pulse: place current player's mark at the cursor
- new_game  in  1  one-cycle pulse: restart after a finished game
- pos_x  out  3  registered cursor column, 0..2
- pos_y  out  3  registered cursor row, 0..2
- board  out  18  cell (x,y) at bits [2*(3*y+x)+:2]; 00 empty, 01 X, 10 O
- player  out  1  side to move: 0 = X, 1 = O
- game_state  out  2  00 PLAY, 01 CHECK, 10 WIN, 11 DRAW
- winner  out  2  00 none, 01 X, 10 O
- occupied_err  out  1  one-cycle pulse: select was issued on a non-empty cell

Behaviour:
- Reset (synchronous, highest priority, legal in any state):
  - pos_x = pos_y = 0, board = 0, player = 0, game_state = PLAY, winner = 00, occupied_err = 0.
- PLAY, cursor movement:
  - move_valid with next_x <= 2 and next_y <= 2: pos_x/pos_y take the new values at the next edge.
  - Any coordinate > 2: the whole proposal is ignored and the position holds.
- PLAY, select on an empty cell:
  - The cell at the current (pre-move) pos is written with code player+1 at the next edge.
  - The FSM goes to CHECK.
- PLAY, select on an occupied cell:
  - Board is unchanged, occupied_err = 1 for exactly one cycle, FSM stays in PLAY.
- select and move_valid in the same cycle: select uses the old position; the move is still applied.
- CHECK (exactly one cycle), evaluated against the updated board for the mark just placed:
  - Any of 8 lines (3 rows, 3 columns, 2 diagonals) all equal to that mark: WIN, winner = player+1, player unchanged.
  - Otherwise, all 9 cells non-empty: DRAW, winner = 00.
  - Otherwise: player toggles and the FSM returns to PLAY.
  - move_valid and select are ignored during CHECK; the pulse is lost and is not queued.
- WIN/DRAW:
  - move_valid and select are ignored; board, winner and pos hold.
  - new_game resets board, player, pos and winner to their reset values and enters PLAY next cycle.
  - new_game is ignored in PLAY and CHECK.
- Latency:
  - select to board update: 1 cycle.
  - select to WIN/DRAW visible: 2 cycles.
  - move_valid to pos update: 1 cycle.
- 11 cell code: never written. If present, it is treated as occupied and never matches a line.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package gato_pkg:
  - cell codes CELL_EMPTY/CELL_X/CELL_O
  - state encodings ST_PLAY/ST_CHECK/ST_WIN/ST_DRAW
  - GRID constant
  - cell-index helper function (3*y+x)
- Sub-module gato_win_check:
  - purely combinational: board[17:0] and mark[1:0] in, line_hit and board_full out.
  - instantiated once by gato_board_ctrl.

Test Plan:
- Reset then idle: pos=(0,0), board=0, player=0, game_state=00, winner=00. Pulse move_valid with next=(2,1): pos=(2,1) one cycle later.
- Illegal coordinate: move_valid with next=(3,0) -> pos unchanged.
- Player alternation and occupied cell:
  - select at (0,0) -> cell 0 = 01, CHECK for one cycle, then player=1.
  - A second select at (0,0) -> occupied_err pulses 1 cycle, board unchanged, player stays 1.
- X wins on a row: X plays (0,0),(1,0),(2,0) interleaved with O at (0,1),(1,1) -> game_state=10, winner=01 two cycles after the last select.
  - Further selects/moves are ignored.
  - new_game -> board=0, player=0, PLAY.
- Draw: fill in order X(0,0) O(1,0) X(2,0) O(1,1) X(0,1) O(2,1) X(1,2) O(0,2) X(2,2) -> game_state=11, winner=00.
- Reset mid-game in CHECK: assert reset during the CHECK cycle -> all outputs return to reset values next edge, with no WIN/DRAW transition.
  - Simultaneous select+move_valid in PLAY -> mark placed at the old pos, pos updated.

Source files
------------

// File: rtl/gato_pkg.sv
// gato_pkg: shared constants for the tic-tac-toe board controller.
//   - cell codes stored in the 2-bit board fields
//   - game_state encodings driven to the display stage
//   - GRID side length and the (x,y) -> linear cell index helper
package gato_pkg;

    localparam int GRID = 3;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] ST_PLAY  = 2'b00;
    localparam logic [1:0] ST_CHECK = 2'b01;
    localparam logic [1:0] ST_WIN   = 2'b10;
    localparam logic [1:0] ST_DRAW  = 2'b11;

    // Linear cell index 3*y + x; the board field for a cell sits at bit 2*index.
    function automatic logic [3:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
        return 4'(y) * 4'd3 + 4'(x);
    endfunction

endpackage

// File: rtl/gato_win_check.sv
// gato_win_check: combinational line/full detector for the 3x3 board.
//   board[17:0]  in   cell (x,y) at bits [2*(3*y+x)+:2]
//   mark[1:0]    in   mark to look for (CELL_X or CELL_O)
//   line_hit     out  some row, column or diagonal is entirely 'mark'
//   board_full   out  no empty cell remains (code 11 counts as occupied)
module gato_win_check
    import gato_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  mark,
    output logic        line_hit,
    output logic        board_full
);

    logic [8:0] cell_used;
    logic [8:0] cell_is_mark;
    logic [7:0] line_match;
    logic       mark_ok;

    // Only a real player mark may match; this keeps a stray 11 cell from ever
    // forming a line.
    assign mark_ok = (mark == CELL_X) || (mark == CELL_O);

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_cell
            assign cell_used[gi]    = (board[2*gi +: 2] != CELL_EMPTY);
            assign cell_is_mark[gi] = (board[2*gi +: 2] == mark);
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_rowcol
            // row gi: cells 3gi .. 3gi+2; column gi: cells gi, gi+3, gi+6
            assign line_match[gi]     = cell_is_mark[3*gi] & cell_is_mark[3*gi+1] & cell_is_mark[3*gi+2];
            assign line_match[3 + gi] = cell_is_mark[gi] & cell_is_mark[gi+3] & cell_is_mark[gi+6];
        end
    endgenerate

    assign line_match[6] = cell_is_mark[0] & cell_is_mark[4] & cell_is_mark[8];
    assign line_match[7] = cell_is_mark[2] & cell_is_mark[4] & cell_is_mark[6];

    assign line_hit   = mark_ok & (|line_match);
    assign board_full = &cell_used;

endmodule

// File: rtl/gato_board_ctrl.sv
// gato_board_ctrl: cursor register, board owner and game FSM for tic-tac-toe.
//   clk, reset        rising-edge clock, synchronous active-high reset
//   move_valid        pulse: next_x/next_y carry a cursor proposal
//   next_x, next_y    proposed cursor from the arithmetic stage
//   select            pulse: place the side-to-move's mark at the cursor
//   new_game          pulse: restart once a game has finished
//   pos_x, pos_y      registered cursor (fed back to the arithmetic stage)
//   board             3x3 board, 2 bits per cell
//   player            side to move: 0 = X, 1 = O
//   game_state        00 PLAY, 01 CHECK, 10 WIN, 11 DRAW
//   winner            00 none, 01 X, 10 O
//   occupied_err      pulse: select hit a non-empty cell
// All outputs come straight from flops.
module gato_board_ctrl
    import gato_pkg::*;
#(
    parameter int GRID  = 3,
    parameter int POS_W = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       move_valid,
    input  logic [POS_W-1:0]           next_x,
    input  logic [POS_W-1:0]           next_y,
    input  logic                       select,
    input  logic                       new_game,
    output logic [POS_W-1:0]           pos_x,
    output logic [POS_W-1:0]           pos_y,
    output logic [2*GRID*GRID-1:0]     board,
    output logic                       player,
    output logic [1:0]                 game_state,
    output logic [1:0]                 winner,
    output logic                       occupied_err
);

    localparam logic [POS_W-1:0] MAX_POS = POS_W'(GRID - 1);

    logic [POS_W-1:0]       pos_x_q, pos_x_d;
    logic [POS_W-1:0]       pos_y_q, pos_y_d;
    logic [2*GRID*GRID-1:0] board_q, board_d;
    logic                   player_q, player_d;
    logic [1:0]             state_q, state_d;
    logic [1:0]             winner_q, winner_d;
    logic                   occupied_err_q, occupied_err_d;

    logic [1:0] mark;
    logic [4:0] cur_bit;
    logic       line_hit;
    logic       board_full;

    // Code of the side to move is simply player+1.
    assign mark    = player_q ? CELL_O : CELL_X;
    assign cur_bit = {cell_idx(pos_x_q, pos_y_q), 1'b0};

    // In CHECK the board register already holds the mark just placed and
    // player_q still names the side that placed it.
    gato_win_check u_win_check (
        .board      (board_q),
        .mark       (mark),
        .line_hit   (line_hit),
        .board_full (board_full)
    );

    always_comb begin
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        board_d        = board_q;
        player_d       = player_q;
        state_d        = state_q;
        winner_d       = winner_q;
        occupied_err_d = 1'b0;

        case (state_q)
            ST_PLAY: begin
                // select reads the pre-move cursor; a simultaneous move still lands.
                if (select) begin
                    if (board_q[cur_bit +: 2] == CELL_EMPTY) begin
                        board_d[cur_bit +: 2] = mark;
                        state_d               = ST_CHECK;
                    end else begin
                        occupied_err_d = 1'b1;
                    end
                end
                // An out-of-range coordinate discards the whole proposal.
                if (move_valid && (next_x <= MAX_POS) && (next_y <= MAX_POS)) begin
                    pos_x_d = next_x;
                    pos_y_d = next_y;
                end
            end
            ST_CHECK: begin
                if (line_hit) begin
                    state_d  = ST_WIN;
                    winner_d = mark;
                end else if (board_full) begin
                    state_d = ST_DRAW;
                end else begin
                    player_d = ~player_q;
                    state_d  = ST_PLAY;
                end
            end
            default: begin
                // WIN / DRAW: frozen until new_game.
                if (new_game) begin
                    pos_x_d  = '0;
                    pos_y_d  = '0;
                    board_d  = '0;
                    player_d = 1'b0;
                    winner_d = CELL_EMPTY;
                    state_d  = ST_PLAY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_q        <= '0;
            pos_y_q        <= '0;
            board_q        <= '0;
            player_q       <= 1'b0;
            state_q        <= ST_PLAY;
            winner_q       <= CELL_EMPTY;
            occupied_err_q <= 1'b0;
        end else begin
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            board_q        <= board_d;
            player_q       <= player_d;
            state_q        <= state_d;
            winner_q       <= winner_d;
            occupied_err_q <= occupied_err_d;
        end
    end

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign board        = board_q;
    assign player       = player_q;
    assign game_state   = state_q;
    assign winner       = winner_q;
    assign occupied_err = occupied_err_q;

endmodule

// File: tb/tb_gato_board_ctrl.sv
// Self-checking bench for gato_board_ctrl: directed test-plan steps followed by
// random stimulus, all compared every cycle against a game-level model.
module tb_gato_board_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        move_valid = 1'b0;
    logic [2:0]  next_x = 3'd0;
    logic [2:0]  next_y = 3'd0;
    logic        select = 1'b0;
    logic        new_game = 1'b0;
    logic [2:0]  pos_x;
    logic [2:0]  pos_y;
    logic [17:0] board;
    logic        player;
    logic [1:0]  game_state;
    logic [1:0]  winner;
    logic        occupied_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gato_board_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .move_valid   (move_valid),
        .next_x       (next_x),
        .next_y       (next_y),
        .select       (select),
        .new_game     (new_game),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .board        (board),
        .player       (player),
        .game_state   (game_state),
        .winner       (winner),
        .occupied_err (occupied_err)
    );

    // ---------------- game model ----------------
    // m_cell[x][y]: 0 empty, 1 X, 2 O. m_phase: 0 play, 1 check, 2 win, 3 draw.
    int m_cell [3][3];
    int m_px, m_py, m_player, m_phase, m_winner, m_occ;

    function automatic bit m_has_line(int mark);
        bit won = 0;
        for (int i = 0; i < 3; i++) begin
            int row_cnt = 0;
            int col_cnt = 0;
            for (int j = 0; j < 3; j++) begin
                if (m_cell[j][i] == mark) row_cnt++;
                if (m_cell[i][j] == mark) col_cnt++;
            end
            if (row_cnt == 3 || col_cnt == 3) won = 1;
        end
        if (m_cell[0][0] == mark && m_cell[1][1] == mark && m_cell[2][2] == mark) won = 1;
        if (m_cell[2][0] == mark && m_cell[1][1] == mark && m_cell[0][2] == mark) won = 1;
        return won;
    endfunction

    task automatic m_clear();
        for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++)
                m_cell[x][y] = 0;
        m_px = 0; m_py = 0; m_player = 0; m_winner = 0;
    endtask

    task automatic m_update(bit mv, int nx, int ny, bit sel, bit ng, bit rst);
        int filled;
        if (rst) begin
            m_clear();
            m_phase = 0;
            m_occ   = 0;
            return;
        end
        m_occ = 0;
        case (m_phase)
            0: begin
                if (sel) begin
                    if (m_cell[m_px][m_py] == 0) begin
                        m_cell[m_px][m_py] = m_player + 1;
                        m_phase = 1;
                    end else begin
                        m_occ = 1;
                    end
                end
                if (mv && nx < 3 && ny < 3) begin
                    m_px = nx;
                    m_py = ny;
                end
            end
            1: begin
                filled = 0;
                for (int x = 0; x < 3; x++)
                    for (int y = 0; y < 3; y++)
                        if (m_cell[x][y] != 0) filled++;
                if (m_has_line(m_player + 1)) begin
                    m_phase  = 2;
                    m_winner = m_player + 1;
                end else if (filled == 9) begin
                    m_phase = 3;
                end else begin
                    m_player = 1 - m_player;
                    m_phase  = 0;
                end
            end
            default: begin
                if (ng) begin
                    m_clear();
                    m_phase = 0;
                end
            end
        endcase
    endtask

    function automatic logic [17:0] m_board();
        logic [17:0] b = '0;
        for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++)
                b[2*(3*y+x) +: 2] = 2'(m_cell[x][y]);
        return b;
    endfunction

    // ---------------- checking ----------------
    task automatic check(string tag, logic [17:0] got, logic [17:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".pos_x"},  18'(pos_x),        18'(m_px));
        check({tag, ".pos_y"},  18'(pos_y),        18'(m_py));
        check({tag, ".board"},  board,             m_board());
        check({tag, ".player"}, 18'(player),       18'(m_player));
        check({tag, ".state"},  18'(game_state),   18'(m_phase));
        check({tag, ".winner"}, 18'(winner),       18'(m_winner));
        check({tag, ".occ"},    18'(occupied_err), 18'(m_occ));
    endtask

    // One clock cycle: drive at negedge, model the edge, compare 1 time unit later.
    task automatic step(string tag, bit mv, int nx, int ny, bit sel, bit ng, bit rst);
        @(negedge clk);
        move_valid = mv;
        next_x     = 3'(nx);
        next_y     = 3'(ny);
        select     = sel;
        new_game   = ng;
        reset      = rst;
        @(posedge clk);
        m_update(mv, nx, ny, sel, ng, rst);
        #1;
        check_all(tag);
        $display("step %-10s mv=%0b nxt=(%0d,%0d) sel=%0b ng=%0b rst=%0b -> pos=(%0d,%0d) board=%05h ply=%0b st=%0d win=%0d occ=%0b",
                 tag, mv, nx, ny, sel, ng, rst, pos_x, pos_y, board, player, game_state, winner, occupied_err);
        move_valid = 1'b0;
        select     = 1'b0;
        new_game   = 1'b0;
        reset      = 1'b0;
    endtask

    // Move cursor, select, then spend the CHECK cycle.
    task automatic place(string tag, int x, int y);
        step({tag, "_mv"},  1, x, y, 0, 0, 0);
        step({tag, "_sel"}, 0, 0, 0, 1, 0, 0);
        step({tag, "_chk"}, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_clear();
        m_phase = 0;
        m_occ   = 0;

        // Reset and idle
        step("reset", 0, 0, 0, 0, 0, 1);
        step("idle", 0, 0, 0, 0, 0, 0);
        check("rst_board", board, 18'h0);
        check("rst_state", 18'(game_state), 18'd0);
        step("move21", 1, 2, 1, 0, 0, 0);
        check("move21_x", 18'(pos_x), 18'd2);
        check("move21_y", 18'(pos_y), 18'd1);
        step("move30", 1, 3, 0, 0, 0, 0);
        check("illegal_x", 18'(pos_x), 18'd2);

        // Alternation and occupied cell
        step("mv00", 1, 0, 0, 0, 0, 0);
        step("selX00", 0, 0, 0, 1, 0, 0);
        check("check_state", 18'(game_state), 18'd1);
        check("cell0_x", 18'(board), 18'h1);
        step("chk", 0, 0, 0, 0, 0, 0);
        check("player_o", 18'(player), 18'd1);
        step("selO00", 0, 0, 0, 1, 0, 0);
        check("occ_pulse", 18'(occupied_err), 18'd1);
        step("after_occ", 0, 0, 0, 0, 0, 0);
        check("occ_clear", 18'(occupied_err), 18'd0);
        check("occ_player", 18'(player), 18'd1);

        // X wins on row 0
        step("rst2", 0, 0, 0, 0, 0, 1);
        place("X00", 0, 0);
        place("O01", 0, 1);
        place("X10", 1, 0);
        place("O11", 1, 1);
        place("X20", 2, 0);
        check("win_state", 18'(game_state), 18'd2);
        check("win_who", 18'(winner), 18'd1);
        step("ign_mv", 1, 1, 2, 1, 0, 0);
        step("ign_sel", 0, 0, 0, 1, 0, 0);
        step("newgame", 0, 0, 0, 0, 1, 0);
        check("ng_board", board, 18'h0);
        check("ng_state", 18'(game_state), 18'd0);

        // Draw
        place("dX00", 0, 0);
        place("dO10", 1, 0);
        place("dX20", 2, 0);
        place("dO11", 1, 1);
        place("dX01", 0, 1);
        place("dO21", 2, 1);
        place("dX12", 1, 2);
        place("dO02", 0, 2);
        place("dX22", 2, 2);
        check("draw_state", 18'(game_state), 18'd3);
        check("draw_who", 18'(winner), 18'd0);
        step("ng_ignored_no", 0, 0, 0, 0, 1, 0);

        // Reset during CHECK
        step("mv11", 1, 1, 1, 0, 0, 0);
        step("sel11", 0, 0, 0, 1, 0, 0);
        step("rst_chk", 0, 0, 0, 0, 0, 1);
        check("rstchk_state", 18'(game_state), 18'd0);
        check("rstchk_board", board, 18'h0);

        // select + move in the same cycle
        step("selmv", 1, 2, 2, 1, 0, 0);
        check("selmv_board", board, 18'h1);
        check("selmv_x", 18'(pos_x), 18'd2);
        step("selmv_chk", 0, 0, 0, 0, 0, 0);
        // new_game ignored in PLAY
        step("ng_play", 0, 0, 0, 0, 1, 0);

        // Random play
        for (int i = 0; i < 1500; i++) begin
            step("rand",
                 bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 99) < 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
